// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
//   Multi-channel programmable clock divider / enable generator. Each channel
//   runs its own period counter and produces a registered divided clock plus a
//   one-cycle tick at the start of every period. Divide ratio and high time are
//   written into per-channel shadow registers and only take effect at a period
//   boundary (or while the channel is stopped), so the outputs never glitch.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   en_i         per-channel run enable
//   load_i       write strobe for the shadow registers
//   load_ch_i    channel addressed by load_i
//   load_div_i   new divide ratio (period in clk cycles), clamped to >= 2
//   load_high_i  new high time in clk cycles, clamped to < divide ratio
//   clk_out_o    divided clock, registered
//   tick_o       1-cycle pulse at the start of each period
//   pending_o    shadow loaded but not yet applied
// -----------------------------------------------------------------------------
module clk_div_multi #(
    parameter int NUM_CH       = 4,
    parameter int DIV_W        = 16,
    parameter int DEFAULT_DIV  = 16,
    parameter int DEFAULT_HIGH = 8,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              load_i,
    input  logic [CH_W-1:0]   load_ch_i,
    input  logic [DIV_W-1:0]  load_div_i,
    input  logic [DIV_W-1:0]  load_high_i,
    output logic [NUM_CH-1:0] clk_out_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] pending_o
);

    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] HIGH_RST = DIV_W'(DEFAULT_HIGH);
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO      = DIV_W'(2);

    logic [DIV_W-1:0]  cnt_q         [NUM_CH];
    logic [DIV_W-1:0]  cnt_d         [NUM_CH];
    logic [DIV_W-1:0]  div_act_q     [NUM_CH];
    logic [DIV_W-1:0]  div_act_d     [NUM_CH];
    logic [DIV_W-1:0]  high_act_q    [NUM_CH];
    logic [DIV_W-1:0]  high_act_d    [NUM_CH];
    logic [DIV_W-1:0]  shadow_div_q  [NUM_CH];
    logic [DIV_W-1:0]  shadow_div_d  [NUM_CH];
    logic [DIV_W-1:0]  shadow_high_q [NUM_CH];
    logic [DIV_W-1:0]  shadow_high_d [NUM_CH];
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] pending_q, pending_d;

    // Clamped load values are shared by all channels; only the addressed one
    // captures them.
    logic [DIV_W-1:0] ld_div_c;
    logic [DIV_W-1:0] ld_high_c;

    assign ld_div_c  = (load_div_i < TWO) ? TWO : load_div_i;
    assign ld_high_c = (load_high_i >= ld_div_c) ? (ld_div_c - ONE) : load_high_i;

    always_comb begin
        logic last;
        // NOTE: every combinational output gets a default before any branch so
        // that no path leaves it unassigned and a latch is never inferred.
        cnt_d         = cnt_q;
        div_act_d     = div_act_q;
        high_act_d    = high_act_q;
        shadow_div_d  = shadow_div_q;
        shadow_high_d = shadow_high_q;
        clk_out_d     = '0;
        tick_d        = '0;
        pending_d     = pending_q;
        last          = 1'b0;

        for (int ch = 0; ch < NUM_CH; ch++) begin
            last = (cnt_q[ch] == div_act_q[ch] - ONE);

            if (en_i[ch]) begin
                cnt_d[ch]     = last ? '0 : cnt_q[ch] + ONE;
                clk_out_d[ch] = (cnt_q[ch] < high_act_q[ch]);
                tick_d[ch]    = (cnt_q[ch] == '0);
            end else begin
                cnt_d[ch] = '0;
            end

            // Apply only at the last cycle of a period or while stopped, so a
            // running period is never truncated or stretched.
            if (pending_q[ch] && (!en_i[ch] || last)) begin
                div_act_d[ch]  = shadow_div_q[ch];
                high_act_d[ch] = shadow_high_q[ch];
                pending_d[ch]  = 1'b0;
            end

            // A load in the same cycle as an apply overrides: the old shadow is
            // applied above and the new one stays pending for the next boundary.
            if (load_i && (int'(load_ch_i) == ch)) begin
                shadow_div_d[ch]  = ld_div_c;
                shadow_high_d[ch] = ld_high_c;
                pending_d[ch]     = 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: every register, including the per-channel arrays, is reset because
    // the shadows and active ratios must hold defined defaults after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch]         <= '0;
                div_act_q[ch]     <= DIV_RST;
                high_act_q[ch]    <= HIGH_RST;
                shadow_div_q[ch]  <= DIV_RST;
                shadow_high_q[ch] <= HIGH_RST;
            end
            clk_out_q <= '0;
            tick_q    <= '0;
            pending_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            div_act_q     <= div_act_d;
            high_act_q    <= high_act_d;
            shadow_div_q  <= shadow_div_d;
            shadow_high_q <= shadow_high_d;
            clk_out_q     <= clk_out_d;
            tick_q        <= tick_d;
            pending_q     <= pending_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
//   Testbench for clk_div_multi. Expected per-cycle outputs of the channel under
//   test are pushed into a scoreboard queue as stimulus is set up, and popped
//   and compared one entry per clock edge, sampled 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en_i;
    logic              load_i;
    logic [1:0]        load_ch_i;
    logic [DIV_W-1:0]  load_div_i;
    logic [DIV_W-1:0]  load_high_i;
    logic [NUM_CH-1:0] clk_out_o;
    logic [NUM_CH-1:0] tick_o;
    logic [NUM_CH-1:0] pending_o;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (16),
        .DEFAULT_HIGH(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en_i),
        .load_i     (load_i),
        .load_ch_i  (load_ch_i),
        .load_div_i (load_div_i),
        .load_high_i(load_high_i),
        .clk_out_o  (clk_out_o),
        .tick_o     (tick_o),
        .pending_o  (pending_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    ch;
        logic  co;
        logic  tk;
        logic  pd;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Expected outputs for n edges of a running channel whose counter starts
    // at start_cnt: clk_out high for the first 'high' counts, tick at count 0.
    task automatic push_pattern(input int ch, input int div, input int high,
                                input int n, input int start_cnt,
                                input logic pd, input string tag);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            int c;
            c     = (start_cnt + k) % div;
            e.ch  = ch;
            e.co  = (c < high);
            e.tk  = (c == 0);
            e.pd  = pd;
            e.tag = tag;
            sb.push_back(e);
        end
    endtask

    task automatic push_one(input int ch, input logic co, input logic tk,
                            input logic pd, input string tag);
        exp_t e;
        e.ch  = ch;
        e.co  = co;
        e.tk  = tk;
        e.pd  = pd;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // One clock edge; pop the next expectation and compare it with the DUT.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow: DUT edge with no expected entry");
        end else begin
            e = sb.pop_front();
            if ({clk_out_o[e.ch], tick_o[e.ch], pending_o[e.ch]} !== {e.co, e.tk, e.pd}) begin
                n_fail++;
                $display("FAIL %s ch%0d @%0t: got clk_out/tick/pending=%b%b%b expected %b%b%b",
                         e.tag, e.ch, $time, clk_out_o[e.ch], tick_o[e.ch],
                         pending_o[e.ch], e.co, e.tk, e.pd);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input int ch, input int div, input int high);
        load_i      = 1'b1;
        load_ch_i   = 2'(ch);
        load_div_i  = DIV_W'(div);
        load_high_i = DIV_W'(high);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (clk_out_o !== '0) begin
            n_fail++;
            $display("FAIL reset_clk_out: got %b expected 0000", clk_out_o);
        end
        n_checks++;
        if (tick_o !== '0) begin
            n_fail++;
            $display("FAIL reset_tick: got %b expected 0000", tick_o);
        end
        n_checks++;
        if (pending_o !== '0) begin
            n_fail++;
            $display("FAIL reset_pending: got %b expected 0000", pending_o);
        end
        rst = 1'b0;
    endtask

    // Defaults after reset: 8 high / 8 low, tick with the first high cycle.
    task automatic test_default_ratio();
        en_i[0] = 1'b1;
        push_pattern(0, 16, 8, 32, 0, 1'b0, "default_16_8");
        run(32);
        en_i[0] = 1'b0;
        push_one(0, 1'b0, 1'b0, 1'b0, "default_stop");
        run(1);
    endtask

    task automatic test_load_disabled();
        do_load(1, 5, 2);
        push_one(1, 1'b0, 1'b0, 1'b1, "idle_load_pending");
        run(1);
        load_i = 1'b0;
        push_one(1, 1'b0, 1'b0, 1'b0, "idle_apply");
        run(1);
        en_i[1] = 1'b1;
        push_pattern(1, 5, 2, 15, 0, 1'b0, "ratio_5_2");
        run(15);
        en_i[1] = 1'b0;
        push_one(1, 1'b0, 1'b0, 1'b0, "ratio_5_2_stop");
        run(1);
    endtask

    // Reload while running: the 16-cycle period in flight must complete.
    task automatic test_midperiod_reload();
        en_i[0] = 1'b1;
        push_pattern(0, 16, 8, 3, 0, 1'b0, "run_pre_load");
        run(3);
        do_load(0, 4, 1);
        push_one(0, 1'b1, 1'b0, 1'b1, "load_at_cnt3");
        run(1);
        load_i = 1'b0;
        push_pattern(0, 16, 8, 11, 4, 1'b1, "old_period_tail");
        push_pattern(0, 16, 8, 1, 15, 1'b0, "boundary_apply");
        push_pattern(0, 4, 1, 12, 0, 1'b0, "new_ratio_4_1");
        run(24);
        en_i[0] = 1'b0;
        push_one(0, 1'b0, 1'b0, 1'b0, "reload_stop");
        run(1);
    endtask

    // Second load lands on the apply edge of the first: the newer value wins.
    task automatic test_back_to_back();
        do_load(1, 3, 1);
        push_one(1, 1'b0, 1'b0, 1'b1, "b2b_first_load");
        run(1);
        do_load(1, 7, 3);
        push_one(1, 1'b0, 1'b0, 1'b1, "b2b_collide_pending");
        run(1);
        load_i = 1'b0;
        push_one(1, 1'b0, 1'b0, 1'b0, "b2b_apply");
        run(1);
        en_i[1] = 1'b1;
        push_pattern(1, 7, 3, 14, 0, 1'b0, "b2b_ratio_7_3");
        run(14);
        en_i[1] = 1'b0;
        push_one(1, 1'b0, 1'b0, 1'b0, "b2b_stop");
        run(1);
    endtask

    task automatic test_clamp();
        do_load(3, 0, 9);
        push_one(3, 1'b0, 1'b0, 1'b1, "clamp_div0_load");
        run(1);
        load_i = 1'b0;
        push_one(3, 1'b0, 1'b0, 1'b0, "clamp_div0_apply");
        run(1);
        en_i[3] = 1'b1;
        push_pattern(3, 2, 1, 6, 0, 1'b0, "clamp_2_1");
        run(6);
        en_i[3] = 1'b0;
        push_one(3, 1'b0, 1'b0, 1'b0, "clamp_2_1_stop");
        run(1);
        do_load(3, 6, 0);
        push_one(3, 1'b0, 1'b0, 1'b1, "high0_load");
        run(1);
        load_i = 1'b0;
        push_one(3, 1'b0, 1'b0, 1'b0, "high0_apply");
        run(1);
        en_i[3] = 1'b1;
        push_pattern(3, 6, 0, 12, 0, 1'b0, "high0_6_0");
        run(12);
        en_i[3] = 1'b0;
        push_one(3, 1'b0, 1'b0, 1'b0, "high0_stop");
        run(1);
    endtask

    task automatic test_en_drop();
        en_i[2] = 1'b1;
        push_pattern(2, 16, 8, 5, 0, 1'b0, "pre_drop");
        run(5);
        en_i[2] = 1'b0;
        push_one(2, 1'b0, 1'b0, 1'b0, "drop_at_cnt5");
        run(1);
        en_i[2] = 1'b1;
        push_pattern(2, 16, 8, 17, 0, 1'b0, "restart_full_period");
        run(17);
        en_i[2] = 1'b0;
        push_one(2, 1'b0, 1'b0, 1'b0, "restart_stop");
        run(1);
    endtask

    // Reset while channel 0 runs 4/1 with a load pending; a load issued with
    // reset must be discarded and defaults restored.
    task automatic test_reset_mid();
        en_i[0] = 1'b1;
        push_pattern(0, 4, 1, 2, 0, 1'b0, "pre_rst_4_1");
        run(2);
        do_load(0, 9, 4);
        push_one(0, 1'b0, 1'b0, 1'b1, "pre_rst_pending");
        run(1);
        rst = 1'b1;
        do_load(0, 10, 5);
        @(posedge clk);
        #1;
        n_checks++;
        if ({clk_out_o, tick_o, pending_o} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got clk_out=%b tick=%b pending=%b expected all 0",
                     clk_out_o, tick_o, pending_o);
        end
        rst    = 1'b0;
        load_i = 1'b0;
        push_pattern(0, 16, 8, 17, 0, 1'b0, "post_rst_defaults");
        run(17);
        en_i[0] = 1'b0;
        push_one(0, 1'b0, 1'b0, 1'b0, "post_rst_stop");
        run(1);
    endtask

    initial begin
        rst         = 1'b1;
        en_i        = '0;
        load_i      = 1'b0;
        load_ch_i   = '0;
        load_div_i  = '0;
        load_high_i = '0;

        test_reset();
        test_default_ratio();
        test_load_disabled();
        test_midperiod_reload();
        test_back_to_back();
        test_clamp();
        test_en_drop();
        test_reset_mid();

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
